// File: rtl/dm_shadow_pkg.sv
// rtl/dm_shadow_pkg.sv - size encodings, lane helpers and pending-phase type for the DM shadow checker
package dm_shadow_pkg;

  // Helpers work on the widest supported word; callers truncate to their own lane count.
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HWORD = 2'd1,
    SIZE_WORD  = 2'd2
  } size_e;

  typedef struct packed {
    logic valid;
    logic write;
  } pending_t;

  function automatic logic [MAX_BYTES-1:0] size_to_strobe(input size_e size, input logic [5:0] addr_lo);
    case (size)
      SIZE_BYTE:  return MAX_BYTES'(1) << addr_lo;
      SIZE_HWORD: return MAX_BYTES'(3) << addr_lo;
      default:    return '1;
    endcase
  endfunction

  function automatic logic is_aligned(input size_e size, input logic [5:0] addr_lo);
    case (size)
      SIZE_BYTE:  return 1'b1;
      SIZE_HWORD: return ~addr_lo[0];
      default:    return addr_lo == 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_shadow_mem_checker_if.sv
// rtl/dm_shadow_mem_checker_if.sv - CPU data-memory port signals as seen by the shadow checker
interface dm_shadow_mem_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 3
);
  logic              D_req;
  logic              D_wait;
  logic              D_write;
  logic [SIZE_W-1:0] D_type;
  logic [ADDR_W-1:0] D_addr;
  logic [DATA_W-1:0] D_in;
  logic [DATA_W-1:0] D_out;

  modport master (output D_req, D_wait, D_write, D_type, D_addr, D_in, D_out);
  modport slave  (input  D_req, D_wait, D_write, D_type, D_addr, D_in, D_out);
endinterface

// File: rtl/dm_shadow_entry.sv
// rtl/dm_shadow_entry.sv - one tracked word: shadow bytes, written-byte flags and read compare
module dm_shadow_entry #(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [NB-1:0]     strb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data,
  output logic [NB-1:0]     known,
  output logic              mismatch
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      known <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) begin
          data[b*8 +: 8] <= wr_data[b*8 +: 8];
          known[b]       <= 1'b1;
        end
      end
    end
  end

  // Bytes never written carry no expectation, so they cannot flag.
  always_comb begin
    mismatch = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (strb[b] && known[b] && (data[b*8 +: 8] != rd_data[b*8 +: 8])) mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/dm_shadow_mem_checker.sv
// rtl/dm_shadow_mem_checker.sv - observe-only shadow of N tracked data-memory words with registered read checks
module dm_shadow_mem_checker
  import dm_shadow_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int N_ENTRIES = 4,
  parameter int SIZE_W    = 3,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB),
  localparam int EW    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  dm_shadow_mem_checker_if.slave      bus,
  input  logic [N_ENTRIES*ADDR_W-1:0] target_addr,
  output logic                        chk_valid,
  output logic                        chk_mismatch,
  output logic [EW-1:0]               chk_entry,
  output logic [DATA_W-1:0]           exp_data,
  output logic [N_ENTRIES*NB-1:0]     known_mask,
  output logic                        err_align,
  output logic                        err_size
);

  pending_t                pend;
  logic [N_ENTRIES-1:0]    pend_hit, req_hit;
  logic [NB-1:0]           pend_strb, req_strb;
  logic [OFF_W-1:0]        addr_lo;
  size_e                   req_size;
  logic                    size_ok, align_ok, capture, complete, rd_check;
  logic [EW-1:0]           sel;
  logic [N_ENTRIES*DATA_W-1:0] ent_data;
  logic [N_ENTRIES-1:0]    ent_mism;
  logic [N_ENTRIES*OFF_W-1:0] unused_tgt_lo;

  assign addr_lo  = bus.D_addr[OFF_W-1:0];
  assign req_size = size_e'(bus.D_type[1:0]);

  always_comb begin
    size_ok = 1'b0;
    if (bus.D_type == SIZE_W'(SIZE_BYTE))       size_ok = 1'b1;
    else if (bus.D_type == SIZE_W'(SIZE_HWORD)) size_ok = (NB >= 2);
    else if (bus.D_type == SIZE_W'(SIZE_WORD))  size_ok = (NB >= 4);
  end

  assign align_ok = is_aligned(req_size, 6'(addr_lo));
  // Illegal transfers still occupy the data phase but hit nothing, so they have no effect.
  assign req_strb = (size_ok && align_ok) ? NB'(size_to_strobe(req_size, 6'(addr_lo))) : '0;

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_hit
    assign req_hit[i] = size_ok && align_ok &&
                        (bus.D_addr[ADDR_W-1:OFF_W] == target_addr[i*ADDR_W+OFF_W +: ADDR_W-OFF_W]);
    assign unused_tgt_lo[i*OFF_W +: OFF_W] = target_addr[i*ADDR_W +: OFF_W];
  end

  assign complete = pend.valid & ~bus.D_wait;
  assign capture  = bus.D_req & (~pend.valid | ~bus.D_wait);
  assign rd_check = complete & ~pend.write & (|pend_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      pend_hit  <= '0;
      pend_strb <= '0;
      err_align <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      if (capture) begin
        pend      <= '{valid: 1'b1, write: bus.D_write};
        pend_hit  <= req_hit;
        pend_strb <= req_strb;
        if (!size_ok)       err_size  <= 1'b1;
        else if (!align_ok) err_align <= 1'b1;
      end else if (complete) begin
        pend.valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
    dm_shadow_entry #(.DATA_W(DATA_W)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (complete & pend.write & pend_hit[i]),
      .strb     (pend_strb),
      .wr_data  (bus.D_in),
      .rd_data  (bus.D_out),
      .data     (ent_data[i*DATA_W +: DATA_W]),
      .known    (known_mask[i*NB +: NB]),
      .mismatch (ent_mism[i])
    );
  end

  // Duplicate targets: the lowest-index hit is the one reported.
  always_comb begin
    sel = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (pend_hit[i]) sel = EW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid    <= 1'b0;
      chk_mismatch <= 1'b0;
      chk_entry    <= '0;
      exp_data     <= '0;
    end else begin
      chk_valid    <= rd_check;
      chk_mismatch <= 1'b0;
      if (rd_check) begin
        chk_mismatch <= ent_mism[sel];
        chk_entry    <= sel;
        exp_data     <= ent_data[sel*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_dm_shadow_mem_checker.sv
// tb/tb_dm_shadow_mem_checker.sv - scoreboard bench for the DM shadow memory checker
module tb_dm_shadow_mem_checker;
  localparam int DATA_W = 32, ADDR_W = 32, N_ENTRIES = 4, SIZE_W = 3;

  typedef struct {
    logic [1:0]  entry;
    logic [31:0] data;
    logic        mism;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [N_ENTRIES*ADDR_W-1:0] target_addr;
  logic        chk_valid, chk_mismatch, err_align, err_size;
  logic [1:0]  chk_entry;
  logic [31:0] exp_data;
  logic [15:0] known_mask;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] tgt[4] = '{32'h100, 32'h200, 32'h300, 32'h300};
  logic [31:0] m_data[4];
  logic [3:0]  m_known[4];

  dm_shadow_mem_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

  dm_shadow_mem_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_ENTRIES(N_ENTRIES), .SIZE_W(SIZE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .target_addr  (target_addr),
    .chk_valid    (chk_valid),
    .chk_mismatch (chk_mismatch),
    .chk_entry    (chk_entry),
    .exp_data     (exp_data),
    .known_mask   (known_mask),
    .err_align    (err_align),
    .err_size     (err_size)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lane_strb(input logic [31:0] addr, input logic [2:0] typ);
    if (typ == 3'd0) return 4'b0001 << addr[1:0];
    if (typ == 3'd1) return 4'b0011 << addr[1:0];
    return 4'b1111;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i]  = '0;
      m_known[i] = '0;
    end
    sb.delete();
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] data);
    logic [3:0] s;
    s = lane_strb(addr, typ);
    for (int i = 0; i < 4; i++) begin
      if (tgt[i][31:2] == addr[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            m_data[i][b*8 +: 8] = data[b*8 +: 8];
            m_known[i][b]       = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] dout);
    logic [3:0] s;
    exp_t x;
    int hit;
    hit = -1;
    s = lane_strb(addr, typ);
    for (int i = 3; i >= 0; i--) if (tgt[i][31:2] == addr[31:2]) hit = i;
    if (hit >= 0) begin
      x.entry = 2'(hit);
      x.data  = m_data[hit];
      x.mism  = 1'b0;
      for (int b = 0; b < 4; b++)
        if (s[b] && m_known[hit][b] && (m_data[hit][b*8 +: 8] != dout[b*8 +: 8])) x.mism = 1'b1;
      sb.push_back(x);
    end
  endtask

  // Address phase, optional wait states (with a competing request the DUT must ignore), data phase.
  task automatic bus_xfer(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] data, input int waits);
    bus.D_req = 1'b1; bus.D_write = wr; bus.D_type = typ; bus.D_addr = addr;
    @(posedge clk); #1;
    bus.D_req = 1'b0;
    for (int w = 0; w < waits; w++) begin
      bus.D_wait = 1'b1; bus.D_in = ~data + 32'(w); bus.D_out = ~data;
      bus.D_req = 1'b1; bus.D_write = 1'b1; bus.D_type = 3'd2; bus.D_addr = 32'h200;
      @(posedge clk); #1;
    end
    bus.D_req = 1'b0; bus.D_wait = 1'b0;
    if (wr) bus.D_in = data; else bus.D_out = data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({chk_valid, chk_mismatch, chk_entry, exp_data, known_mask, err_align, err_size} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b mism=%b entry=%0d exp=%h known=%h ea=%b es=%b, want all 0",
               chk_valid, chk_mismatch, chk_entry, exp_data, known_mask, err_align, err_size);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({chk_valid, exp_data, known_mask, err_align, err_size} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b exp=%h known=%h ea=%b es=%b, want all 0",
               chk_valid, exp_data, known_mask, err_align, err_size);
    end
  endtask

  task automatic test_unknown_read();
    model_read(32'h100, 3'd2, 32'hDEADBEEF);
    bus_xfer(1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL unknown_read: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
  endtask

  task automatic test_word_write();
    model_write(32'h100, 3'd2, 32'h11223344);
    bus_xfer(1'b1, 3'd2, 32'h100, 32'h11223344, 0);
    model_read(32'h100, 3'd2, 32'h11223344);
    bus_xfer(1'b0, 3'd2, 32'h100, 32'h11223344, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL word_match: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (chk_valid !== 1'b0 || exp_data !== 32'h11223344) begin
      n_fail++;
      $display("FAIL valid_pulse: valid=%b exp=%h, want 0 11223344", chk_valid, exp_data);
    end
    model_read(32'h100, 3'd2, 32'h11223345);
    bus_xfer(1'b0, 3'd2, 32'h100, 32'h11223345, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL word_mismatch: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
  endtask

  task automatic test_byte_write();
    model_write(32'h203, 3'd0, 32'hAA000000);
    bus_xfer(1'b1, 3'd0, 32'h203, 32'hAA000000, 0);
    n_cmp++;
    if (known_mask[7:4] !== 4'b1000) begin
      n_fail++;
      $display("FAIL byte_known: known[1]=%b, want 1000", known_mask[7:4]);
    end
    model_read(32'h200, 3'd2, 32'hAA000000);
    bus_xfer(1'b0, 3'd2, 32'h200, 32'hAA000000, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL byte_match: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
    model_read(32'h200, 3'd2, 32'hAB000000);
    bus_xfer(1'b0, 3'd2, 32'h200, 32'hAB000000, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL byte_mismatch: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
  endtask

  task automatic test_wait_states();
    model_write(32'h100, 3'd2, 32'hCAFEF00D);
    bus_xfer(1'b1, 3'd2, 32'h100, 32'hCAFEF00D, 3);
    model_read(32'h100, 3'd2, 32'hCAFEF00D);
    bus_xfer(1'b0, 3'd2, 32'h100, 32'hCAFEF00D, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL wait_data: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
    n_cmp++;
    if (known_mask[7:4] !== 4'b1000) begin
      n_fail++;
      $display("FAIL wait_ignored_req: known[1]=%b, want 1000", known_mask[7:4]);
    end
  endtask

  task automatic test_errors();
    bus_xfer(1'b1, 3'd1, 32'h101, 32'hFFFFFFFF, 0);
    n_cmp++;
    if (err_align !== 1'b1 || err_size !== 1'b0) begin
      n_fail++;
      $display("FAIL err_align: ea=%b es=%b, want 1 0", err_align, err_size);
    end
    model_read(32'h100, 3'd2, 32'hCAFEF00D);
    bus_xfer(1'b0, 3'd2, 32'h100, 32'hCAFEF00D, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || exp_data !== e.data || chk_mismatch !== e.mism || known_mask[3:0] !== 4'hF) begin
      n_fail++;
      $display("FAIL align_no_effect: valid=%b exp=%h mism=%b known0=%h, want 1 %h %b f",
               chk_valid, exp_data, chk_mismatch, known_mask[3:0], e.data, e.mism);
    end
    bus_xfer(1'b1, 3'd3, 32'h100, 32'h00000000, 0);
    n_cmp++;
    if (err_size !== 1'b1 || err_align !== 1'b1) begin
      n_fail++;
      $display("FAIL err_size: es=%b ea=%b, want 1 1", err_size, err_align);
    end
    model_read(32'h100, 3'd2, 32'hCAFEF00D);
    bus_xfer(1'b0, 3'd2, 32'h100, 32'hCAFEF00D, 0);
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL size_no_effect: valid=%b exp=%h mism=%b, want 1 %h %b",
               chk_valid, exp_data, chk_mismatch, e.data, e.mism);
    end
  endtask

  task automatic test_back_to_back();
    bus.D_req = 1'b1; bus.D_write = 1'b1; bus.D_type = 3'd2; bus.D_addr = 32'h300;
    @(posedge clk); #1;
    bus.D_in = 32'h55667788; bus.D_wait = 1'b0;
    bus.D_write = 1'b0; bus.D_addr = 32'h300;
    model_write(32'h300, 3'd2, 32'h55667788);
    model_read(32'h300, 3'd2, 32'h55667788);
    @(posedge clk); #1;
    bus.D_req = 1'b0; bus.D_out = 32'h55667788;
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (chk_valid !== 1'b1 || chk_entry !== e.entry || exp_data !== e.data || chk_mismatch !== e.mism) begin
      n_fail++;
      $display("FAIL b2b_read: valid=%b entry=%0d exp=%h mism=%b, want 1 %0d %h %b",
               chk_valid, chk_entry, exp_data, chk_mismatch, e.entry, e.data, e.mism);
    end
    n_cmp++;
    if (known_mask[15:8] !== 8'hFF) begin
      n_fail++;
      $display("FAIL dup_known: known[3:2]=%h, want ff", known_mask[15:8]);
    end
  endtask

  task automatic test_reset_mid();
    model_write(32'h100, 3'd2, 32'h0BADF00D);
    bus_xfer(1'b1, 3'd2, 32'h100, 32'h0BADF00D, 0);
    bus.D_req = 1'b1; bus.D_write = 1'b0; bus.D_type = 3'd2; bus.D_addr = 32'h100;
    @(posedge clk); #1;
    bus.D_req = 1'b0; bus.D_wait = 1'b1; bus.D_out = 32'hFFFFFFFF;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({chk_valid, chk_mismatch, chk_entry, exp_data, known_mask, err_align, err_size} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b mism=%b entry=%0d exp=%h known=%h ea=%b es=%b, want all 0",
               chk_valid, chk_mismatch, chk_entry, exp_data, known_mask, err_align, err_size);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.D_wait = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (chk_valid !== 1'b0 || exp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_discard: valid=%b exp=%h, want 0 0", chk_valid, exp_data);
    end
    model_reset();
  endtask

  initial begin
    target_addr = {tgt[3], tgt[2], tgt[1], tgt[0]};
    bus.D_req = 1'b0; bus.D_wait = 1'b0; bus.D_write = 1'b0; bus.D_type = '0;
    bus.D_addr = '0; bus.D_in = '0; bus.D_out = '0;
    model_reset();
    test_reset();
    test_unknown_read();
    test_word_write();
    test_byte_write();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
